// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: sequencer state
// encoding, legal parameter ranges and the grant one-hot helper.
package shared_reg_arbiter_pkg;

  // Sequencer states: IDLE arbitrates, HOLD keeps the loaded value stable.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Legal parameter ranges for the arbiter.
  localparam int NUM_REQ_MIN     = 2;
  localparam int NUM_REQ_MAX     = 8;
  localparam int HOLD_CYCLES_MIN = 1;

  // The one-hot helper is sized for the largest legal requester count;
  // callers truncate to their own NUM_REQ.
  localparam int ONEHOT_W = NUM_REQ_MAX;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [2:0] idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or
// above the pointer, wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWN_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [OWN_W-1:0]   idx_o
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin : scan
    int                 cand;
    logic [OWN_W-1:0]   cand_idx;
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand     = (int'(ptr_i) + off) % NUM_REQ;
      cand_idx = OWN_W'(cand);
      if (req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and sequencer for a shared DATA_W-bit register.
// One requester is granted per arbitration; the loaded value is then held
// for HOLD_CYCLES cycles before the next arbitration may happen.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int OWN_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      flush,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid,
  output logic [OWN_W-1:0]          q_owner,
  output logic                      busy
);

  // Counter only ever holds values up to HOLD_CYCLES-1.
  localparam int                CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [OWN_W-1:0]  LAST_IDX = OWN_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [OWN_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;

  logic                pick_valid;
  logic [OWN_W-1:0]    pick_idx;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  // Unpack the flat request data bus into one entry per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Next-state logic: flush overrides everything, IDLE grants, HOLD counts down.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    owner_d = owner_q;
    gnt_d   = '0;

    if (flush) begin
      // Owner and pointer survive a flush so fairness is preserved.
      state_d = ST_IDLE;
      cnt_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_d   = NUM_REQ'(onehot(3'(pick_idx)));
            data_d  = data_arr[pick_idx];
            valid_d = 1'b1;
            owner_d = pick_idx;
            ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + OWN_W'(1);
            cnt_d   = CNT_LOAD;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_valid = valid_q;
  assign q_owner = owner_q;
  assign busy    = (state_q == ST_HOLD);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed vector table,
// a reset-in-hold sequence and randomized traffic against a reference model.
module tb_shared_reg_arbiter;

  localparam int N    = 4;
  localparam int DW   = 3;
  localparam int HOLD = 2;
  localparam int OW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   q;
  logic            q_valid;
  logic [OW-1:0]   q_owner;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shared_reg_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .flush    (flush),
    .gnt      (gnt),
    .q        (q),
    .q_valid  (q_valid),
    .q_owner  (q_owner),
    .busy     (busy)
  );

  typedef struct {
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic            flush;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   q;
    logic            valid;
    logic [OW-1:0]   owner;
    logic            busy;
  } vec_t;

  vec_t vecs[$];

  // Slice data: D0 gives requesters 0..3 the values 1,2,3,4; D5 puts 5 on slice 1.
  localparam logic [N*DW-1:0] D0 = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [N*DW-1:0] D5 = {3'd4, 3'd3, 3'd5, 3'd1};

  function automatic void add(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                              input logic f, input logic [N-1:0] g,
                              input logic [DW-1:0] eq, input logic v,
                              input logic [OW-1:0] o, input logic b);
    vec_t t;
    t.req = r; t.data = d; t.flush = f; t.gnt = g;
    t.q = eq; t.valid = v; t.owner = o; t.busy = b;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] eg, input logic [DW-1:0] eq,
                            input logic ev, input logic [OW-1:0] eo, input logic eb);
    check({tag, " gnt"},     32'(gnt),     32'(eg));
    check({tag, " q"},       32'(q),       32'(eq));
    check({tag, " q_valid"}, 32'(q_valid), 32'(ev));
    check({tag, " q_owner"}, 32'(q_owner), 32'(eo));
    check({tag, " busy"},    32'(busy),    32'(eb));
  endtask

  // Reference model: time-based view of the arbiter. A grant opens a window
  // of HOLD+1 edges during which no new grant can happen.
  int            e;
  int            m_ptr;
  int            m_elig;
  logic [N-1:0]  m_gnt;
  logic [DW-1:0] m_q;
  logic          m_valid;
  int            m_owner;
  logic          m_busy;

  task automatic model_reset();
    e = 0; m_ptr = 0; m_elig = 0; m_gnt = '0;
    m_q = '0; m_valid = 1'b0; m_owner = 0; m_busy = 1'b0;
  endtask

  task automatic model_edge();
    int  k;
    bit  found;
    m_gnt = '0;
    if (flush) begin
      m_q = '0; m_valid = 1'b0; m_elig = e + 1;
    end else if (e >= m_elig && req != '0) begin
      found = 1'b0; k = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && req[(m_ptr + i) % N]) begin
          found = 1'b1; k = (m_ptr + i) % N;
        end
      end
      m_gnt   = N'(1 << k);
      m_q     = req_data[k*DW +: DW];
      m_valid = 1'b1;
      m_owner = k;
      m_ptr   = (k + 1) % N;
      m_elig  = e + HOLD + 1;
    end
    m_busy = (e < m_elig - 1);
    e++;
  endtask

  initial begin
    // Directed table: all-contend, wrap fairness, single request, flush, dropped request.
    add(4'b1111, D0, 0, 4'b0001, 1, 1, 0, 1);
    add(4'b1111, D0, 0, 4'b0000, 1, 1, 0, 1);
    add(4'b1111, D0, 0, 4'b0000, 1, 1, 0, 0);
    add(4'b1111, D0, 0, 4'b0010, 2, 1, 1, 1);
    add(4'b1111, D0, 0, 4'b0000, 2, 1, 1, 1);
    add(4'b1111, D0, 0, 4'b0000, 2, 1, 1, 0);
    add(4'b1111, D0, 0, 4'b0100, 3, 1, 2, 1);
    add(4'b1111, D0, 0, 4'b0000, 3, 1, 2, 1);
    add(4'b1111, D0, 0, 4'b0000, 3, 1, 2, 0);
    add(4'b1111, D0, 0, 4'b1000, 4, 1, 3, 1);
    add(4'b1111, D0, 0, 4'b0000, 4, 1, 3, 1);
    add(4'b1111, D0, 0, 4'b0000, 4, 1, 3, 0);
    add(4'b1001, D0, 0, 4'b0001, 1, 1, 0, 1);
    add(4'b1001, D0, 0, 4'b0000, 1, 1, 0, 1);
    add(4'b1001, D0, 0, 4'b0000, 1, 1, 0, 0);
    add(4'b1001, D0, 0, 4'b1000, 4, 1, 3, 1);
    add(4'b1000, D0, 0, 4'b0000, 4, 1, 3, 1);
    add(4'b1000, D0, 0, 4'b0000, 4, 1, 3, 0);
    add(4'b1000, D0, 0, 4'b1000, 4, 1, 3, 1);
    add(4'b0000, D0, 0, 4'b0000, 4, 1, 3, 1);
    add(4'b0000, D0, 0, 4'b0000, 4, 1, 3, 0);
    add(4'b0000, D0, 0, 4'b0000, 4, 1, 3, 0);
    add(4'b0010, D5, 0, 4'b0010, 5, 1, 1, 1);
    add(4'b0000, D0, 0, 4'b0000, 5, 1, 1, 1);
    add(4'b0000, D0, 0, 4'b0000, 5, 1, 1, 0);
    add(4'b0000, D0, 0, 4'b0000, 5, 1, 1, 0);
    add(4'b0001, D0, 0, 4'b0001, 1, 1, 0, 1);
    add(4'b0100, D0, 1, 4'b0000, 0, 0, 0, 0);
    add(4'b0100, D0, 0, 4'b0100, 3, 1, 2, 1);
    add(4'b0000, D0, 0, 4'b0000, 3, 1, 2, 1);
    add(4'b0000, D0, 0, 4'b0000, 3, 1, 2, 0);
    add(4'b0010, D5, 0, 4'b0010, 5, 1, 1, 1);
    add(4'b0001, D5, 0, 4'b0000, 5, 1, 1, 1);
    add(4'b0001, D5, 0, 4'b0000, 5, 1, 1, 0);
    add(4'b0000, D5, 0, 4'b0000, 5, 1, 1, 0);
    add(4'b0001, D0, 1, 4'b0000, 0, 0, 1, 0);
    add(4'b0001, D0, 0, 4'b0001, 1, 1, 0, 1);
    add(4'b0000, D0, 0, 4'b0000, 1, 1, 0, 1);
    add(4'b0000, D0, 0, 4'b0000, 1, 1, 0, 0);

    // Reset is asynchronous: outputs must clear before any clock edge.
    rst = 1'b1; flush = 1'b0; req = '0; req_data = '0;
    #2;
    check_outs("reset", 4'b0000, 3'd0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      req = vecs[i].req; req_data = vecs[i].data; flush = vecs[i].flush;
      @(posedge clk); #1;
      $display("vec %0d req=%b flush=%b -> gnt=%b q=%0d valid=%b owner=%0d busy=%b",
               i, vecs[i].req, vecs[i].flush, gnt, q, q_valid, q_owner, busy);
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].valid,
                 vecs[i].owner, vecs[i].busy);
    end

    // Reset asserted in the middle of HOLD aborts immediately.
    req = 4'b0010; req_data = D5; flush = 1'b0;
    @(posedge clk); #1;
    check_outs("pre-rst grant", 4'b0010, 3'd5, 1'b1, 2'd1, 1'b1);
    req = '0;
    @(posedge clk); #1;
    check_outs("pre-rst hold", 4'b0000, 3'd5, 1'b1, 2'd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_outs("async rst", 4'b0000, 3'd0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b1001; req_data = D0;
    @(posedge clk); #1;
    $display("post-reset grant gnt=%b q=%0d owner=%0d", gnt, q, q_owner);
    check_outs("post-rst grant", 4'b0001, 3'd1, 1'b1, 2'd0, 1'b1);
    req = '0;

    // Randomized traffic against the reference model.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      req      = N'($urandom_range(0, 15));
      req_data = (N*DW)'($urandom);
      flush    = ($urandom_range(0, 9) == 0);
      model_edge();
      @(posedge clk); #1;
      if (m_gnt != '0)
        $display("rand %0d grant req=%b -> gnt=%b q=%0d owner=%0d", c, req, gnt, q, q_owner);
      check_outs($sformatf("rand%0d", c), m_gnt, m_q, m_valid, OW'(m_owner), m_busy);
    end
    flush = 1'b0; req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
